// File: rtl/aes_sbox_pkg.sv
// Types, affine constants and GF(2^4) composite-field helpers for the AES S-box pipeline.
// GF(16) uses x^4 + x + 1; GF((2^4)^2) uses y^2 + y + {e}.
package aes_sbox_pkg;

  typedef enum logic {SBOX_FWD, SBOX_INV} sbox_mode_e;

  localparam logic [7:0] AFF_FWD_C = 8'h63;
  localparam logic [7:0] AFF_INV_C = 8'h05;

  function automatic logic [3:0] gf16_mul(logic [3:0] a, logic [3:0] b);
    logic [3:0] p;
    logic [3:0] t;
    p = '0;
    t = a;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) p = p ^ t;
      t = {t[2:0], 1'b0} ^ (t[3] ? 4'h3 : 4'h0);
    end
    return p;
  endfunction

  function automatic logic [3:0] gf16_sq(logic [3:0] a);
    return gf16_mul(a, a);
  endfunction

  function automatic logic [3:0] gf16_mul_e(logic [3:0] a);
    return gf16_mul(a, 4'he);
  endfunction

  // a^-1 = a^14 = a^2 * a^4 * a^8; maps 0 to 0.
  function automatic logic [3:0] gf16_inv(logic [3:0] a);
    logic [3:0] a2, a4, a8;
    a2 = gf16_sq(a);
    a4 = gf16_sq(a2);
    a8 = gf16_sq(a4);
    return gf16_mul(gf16_mul(a2, a4), a8);
  endfunction

  // GF(2^8) polynomial basis -> {high, low} nibbles in GF((2^4)^2).
  function automatic logic [7:0] gf_map(logic [7:0] a);
    logic       t_a, t_b, t_c;
    logic [3:0] h, l;
    t_a  = a[1] ^ a[7];
    t_b  = a[5] ^ a[7];
    t_c  = a[4] ^ a[6];
    l[0] = t_c ^ a[0] ^ a[5];
    l[1] = a[1] ^ a[2];
    l[2] = t_a;
    l[3] = a[2] ^ a[4];
    h[0] = t_c ^ a[5];
    h[1] = t_a ^ t_c;
    h[2] = t_b ^ a[2] ^ a[3];
    h[3] = t_b;
    return {h, l};
  endfunction

  function automatic logic [7:0] gf_imap(logic [7:0] x);
    logic       t_a, t_b;
    logic [3:0] h, l;
    logic [7:0] a;
    h    = x[7:4];
    l    = x[3:0];
    t_a  = l[1] ^ h[3];
    t_b  = h[0] ^ h[1];
    a[0] = l[0] ^ h[0];
    a[1] = t_b ^ h[3];
    a[2] = t_a ^ t_b;
    a[3] = t_b ^ l[1] ^ h[2];
    a[4] = t_a ^ t_b ^ l[3];
    a[5] = t_b ^ l[2];
    a[6] = t_a ^ l[2] ^ l[3] ^ h[0];
    a[7] = t_b ^ l[2] ^ h[3];
    return a;
  endfunction

  function automatic logic [7:0] aff_fwd(logic [7:0] a);
    return a ^ {a[6:0], a[7]} ^ {a[5:0], a[7:6]} ^ {a[4:0], a[7:5]} ^ {a[3:0], a[7:4]}
           ^ AFF_FWD_C;
  endfunction

  function automatic logic [7:0] aff_inv(logic [7:0] b);
    return {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ AFF_INV_C;
  endfunction

endpackage

// File: rtl/sbox_lane.sv
// One byte lane of the S-box: combinational front half (up to the GF(16) inverse) and back half.
// Inverse-mode ports exist only when AES_SBOX_INV_EN is defined.
module sbox_lane
  import aes_sbox_pkg::*;
(
`ifdef AES_SBOX_INV_EN
  input  logic       mode_f_i,
  input  logic       mode_b_i,
`endif
  input  logic [7:0] data_i,
  output logic [3:0] ah_o,
  output logic [3:0] hl_o,
  output logic [3:0] dinv_o,
  input  logic [3:0] ah_i,
  input  logic [3:0] hl_i,
  input  logic [3:0] dinv_i,
  output logic [7:0] data_o
);

  logic [7:0] pre;
  logic [7:0] mapped;
  logic [3:0] al;
  logic [3:0] nrm;
  logic [7:0] inv_byte;

`ifdef AES_SBOX_INV_EN
  assign pre = (sbox_mode_e'(mode_f_i) == SBOX_INV) ? aff_inv(data_i) : data_i;
`else
  assign pre = data_i;
`endif

  assign mapped = gf_map(pre);
  assign ah_o   = mapped[7:4];
  assign al     = mapped[3:0];
  assign hl_o   = ah_o ^ al;
  // Norm of (ah*y + al) over GF(16): ah^2*{e} + ah*al + al^2.
  assign nrm    = gf16_mul_e(gf16_sq(ah_o)) ^ gf16_mul(ah_o, al) ^ gf16_sq(al);
  assign dinv_o = gf16_inv(nrm);

  assign inv_byte = gf_imap({gf16_mul(ah_i, dinv_i), gf16_mul(hl_i, dinv_i)});

`ifdef AES_SBOX_INV_EN
  assign data_o = (sbox_mode_e'(mode_b_i) == SBOX_INV) ? inv_byte : aff_fwd(inv_byte);
`else
  assign data_o = aff_fwd(inv_byte);
`endif

endmodule

// File: rtl/aes_sbox_pipe.sv
// Two-stage, multi-lane AES S-box with valid/ready handshake on both sides.
// Define AES_SBOX_INV_EN to support the inverse S-box selected by mode_i.
module aes_sbox_pipe
  import aes_sbox_pkg::*;
#(
  parameter int unsigned LANES = 4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               clear_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic               mode_i,
  input  logic [8*LANES-1:0] data_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [8*LANES-1:0] data_o,
  output logic               busy_o
);

  logic va_q, va_d, vb_q, vb_d;
  logic ready_a, ready_b, load_a, load_b;

  logic [4*LANES-1:0] ah_f, hl_f, dinv_f;
  logic [4*LANES-1:0] ah_q, hl_q, dinv_q;
  logic [8*LANES-1:0] data_b, data_q;

`ifdef AES_SBOX_INV_EN
  sbox_mode_e mode_q;
`else
  logic unused_mode;
  assign unused_mode = mode_i;
`endif

  assign ready_b    = !vb_q || out_ready_i;
  assign ready_a    = !va_q || ready_b;
  assign in_ready_o = ready_a;
  assign load_a     = in_valid_i && ready_a && !clear_i;
  assign load_b     = va_q && ready_b && !clear_i;

  always_comb begin
    va_d = va_q;
    vb_d = vb_q;
    if (clear_i) begin
      va_d = 1'b0;
      vb_d = 1'b0;
    end else begin
      if (ready_a) va_d = in_valid_i;
      if (ready_b) vb_d = va_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      va_q <= 1'b0;
      vb_q <= 1'b0;
    end else begin
      va_q <= va_d;
      vb_q <= vb_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ah_q   <= '0;
      hl_q   <= '0;
      dinv_q <= '0;
`ifdef AES_SBOX_INV_EN
      mode_q <= SBOX_FWD;
`endif
    end else if (load_a) begin
      ah_q   <= ah_f;
      hl_q   <= hl_f;
      dinv_q <= dinv_f;
`ifdef AES_SBOX_INV_EN
      mode_q <= sbox_mode_e'(mode_i);
`endif
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q <= '0;
    end else if (load_b) begin
      data_q <= data_b;
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    sbox_lane u_lane (
`ifdef AES_SBOX_INV_EN
      .mode_f_i (mode_i),
      .mode_b_i (mode_q),
`endif
      .data_i   (data_i[8*k +: 8]),
      .ah_o     (ah_f[4*k +: 4]),
      .hl_o     (hl_f[4*k +: 4]),
      .dinv_o   (dinv_f[4*k +: 4]),
      .ah_i     (ah_q[4*k +: 4]),
      .hl_i     (hl_q[4*k +: 4]),
      .dinv_i   (dinv_q[4*k +: 4]),
      .data_o   (data_b[8*k +: 8])
    );
  end

  assign out_valid_o = vb_q;
  assign data_o      = data_q;
  assign busy_o      = va_q || vb_q;

endmodule

// File: tb/tb_aes_sbox_pipe.sv
// Directed bench for aes_sbox_pipe: reset, hand vectors, exhaustive bytes, backpressure,
// flush and asynchronous reset. Reference model works in the GF(2^8) polynomial basis.
module tb_aes_sbox_pipe;

  localparam int unsigned LANES = 4;
  localparam int unsigned W     = 8 * LANES;

  logic         clk     = 1'b0;
  logic         clk_run = 1'b1;
  logic         rst_n, clear, in_valid, in_ready, mode, out_valid, out_ready, busy;
  logic [W-1:0] din, dout;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int n_out    = 0;

  logic [W-1:0] exp_q[$];
  logic         stall_prev = 1'b0;
  logic [W-1:0] hold_data  = '0;

  always #5 if (clk_run) clk = ~clk;

  aes_sbox_pipe #(.LANES(LANES)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .clear_i     (clear),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .mode_i      (mode),
    .data_i      (din),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .data_o      (dout),
    .busy_o      (busy)
  );

  function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
    logic [7:0] p;
    logic [7:0] t;
    p = '0;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] ginv(logic [7:0] a);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 0; i < 254; i++) r = gmul(r, a);
    return r;
  endfunction

  function automatic logic [7:0] rotl(logic [7:0] b, int n);
    logic [7:0] r;
    r = b;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  function automatic logic [7:0] sbox_m(logic [7:0] x);
    logic [7:0] a;
    a = ginv(x);
    return a ^ rotl(a, 1) ^ rotl(a, 2) ^ rotl(a, 3) ^ rotl(a, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox_m(logic [7:0] y);
    return ginv(rotl(y, 1) ^ rotl(y, 3) ^ rotl(y, 6) ^ 8'h05);
  endfunction

  function automatic logic [W-1:0] model(logic [W-1:0] d, logic m);
    logic [W-1:0] r;
    logic         unused_m;
    unused_m = m;
    for (int k = 0; k < LANES; k++) begin
`ifdef AES_SBOX_INV_EN
      r[8*k +: 8] = m ? inv_sbox_m(d[8*k +: 8]) : sbox_m(d[8*k +: 8]);
`else
      r[8*k +: 8] = sbox_m(d[8*k +: 8]);
`endif
    end
    return r;
  endfunction

  function automatic logic [W-1:0] exh_word(int t);
    logic [W-1:0] w;
    for (int k = 0; k < LANES; k++) w[8*k +: 8] = 8'(t + 64 * k);
    return w;
  endfunction

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs == exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Single transaction into an empty pipe; checks latency and result. Entered at posedge+1.
  task automatic send_one(input string tag, input logic [W-1:0] d, input logic m,
                          input logic [W-1:0] exp);
    in_valid = 1'b1; din = d; mode = m; out_ready = 1'b1; clear = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0; din = '0;
    check_bit({tag, " no early valid"}, out_valid, 1'b0);
    check_bit({tag, " busy in flight"}, busy, 1'b1);
    @(posedge clk); #1;
    check_bit({tag, " out_valid"}, out_valid, 1'b1);
    check({tag, " data"}, dout, exp);
    @(posedge clk); #1;
    check_bit({tag, " idle after"}, busy, 1'b0);
  endtask

  // One streaming cycle with scoreboard. Entered at posedge+1, returns at next posedge+1.
  task automatic step(input logic v, input logic [W-1:0] d, input logic m, input logic ordy,
                      output logic acc);
    logic [W-1:0] e;
    in_valid = v; din = d; mode = m; out_ready = ordy; clear = 1'b0;
    @(negedge clk);
    check_bit("in_ready", in_ready, !(exp_q.size() == 2 && !ordy));
    if (stall_prev) check("data_o held under stall", dout, hold_data);
    stall_prev = out_valid && !ordy;
    hold_data  = dout;
    if (out_valid && ordy) begin
      if (exp_q.size() == 0) begin
        check_bit("output with empty scoreboard", out_valid, 1'b0);
      end else begin
        e = exp_q.pop_front();
        check("stream data", dout, e);
        n_out++;
      end
    end
    acc = v && in_ready;
    if (acc) exp_q.push_back(model(d, m));
    @(posedge clk); #1;
  endtask

  task automatic push_word(input logic [W-1:0] d, input logic m, input bit rnd);
    logic acc;
    int   tries;
    acc   = 1'b0;
    tries = 0;
    while (!acc && tries < 50) begin
      step(1'b1, d, m, rnd ? 1'($urandom_range(0, 1)) : 1'b1, acc);
      tries++;
    end
    if (!acc) check_bit("accept timeout", acc, 1'b1);
  endtask

  task automatic drain();
    logic acc;
    int   n;
    n = 0;
    while (exp_q.size() > 0 && n < 20) begin
      step(1'b0, '0, 1'b0, 1'b1, acc);
      n++;
    end
    check_int("drain leftover", exp_q.size(), 0);
    check_bit("idle after drain", busy, 1'b0);
    stall_prev = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; din = '0; mode = 1'b0; out_ready = 1'b0;
    #12;
    check_bit("reset out_valid", out_valid, 1'b0);
    check("reset data_o", dout, '0);
    check_bit("reset busy", busy, 1'b0);
    check_bit("reset in_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    send_one("fwd 53020100", 32'h53020100, 1'b0, 32'hED777C63);
    send_one("fwd ffaa5510", 32'hFFAA5510, 1'b0, 32'h16ACFCCA);
    send_one("fwd 11035003", 32'h11035003, 1'b0, 32'h827B537B);
`ifdef AES_SBOX_INV_EN
    send_one("inv 53777c63", 32'h53777C63, 1'b1, 32'h50020100);
    send_one("inv 16acfcca", 32'h16ACFCCA, 1'b1, 32'hFFAA5510);
`else
    send_one("mode ignored", 32'h53020100, 1'b1, 32'hED777C63);
`endif

    for (int t = 0; t < 256; t++) push_word(exh_word(t), 1'b0, 1'b0);
    drain();
`ifdef AES_SBOX_INV_EN
    for (int t = 0; t < 256; t++) push_word(exh_word(t), 1'b1, 1'b0);
    drain();
`endif

    n_out = 0;
    for (int i = 0; i < 8; i++) begin
`ifdef AES_SBOX_INV_EN
      push_word(W'($urandom), 1'($urandom_range(0, 1)), 1'b1);
`else
      push_word(W'($urandom), 1'b0, 1'b1);
`endif
    end
    drain();
    check_int("backpressure output count", n_out, 8);

    // Flush with two words in flight; the word offered alongside clear is dropped.
    in_valid = 1'b1; din = 32'h00112233; mode = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    din = 32'h44556677;
    @(posedge clk); #1;
    check_bit("full in_ready", in_ready, 1'b0);
    check_bit("full out_valid", out_valid, 1'b1);
    clear = 1'b1; din = 32'h8899AABB;
    @(posedge clk); #1;
    clear = 1'b0; in_valid = 1'b0;
    check_bit("flush out_valid", out_valid, 1'b0);
    check_bit("flush busy", busy, 1'b0);
    @(posedge clk); #1;
    check_bit("flush dropped input", busy, 1'b0);
    send_one("after flush", 32'h00010203, 1'b0, 32'h637C777B);

    // Asynchronous reset with the clock stopped.
    in_valid = 1'b1; din = 32'h53020100; out_ready = 1'b0;
    @(posedge clk); #1;
    din = 32'hFFAA5510;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_bit("pre-reset out_valid", out_valid, 1'b1);
    @(negedge clk);
    clk_run = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_bit("async reset out_valid", out_valid, 1'b0);
    check_bit("async reset busy", busy, 1'b0);
    check("async reset data_o", dout, '0);
    check_bit("async reset in_ready", in_ready, 1'b1);
    #3 rst_n = 1'b1;
    #2 clk_run = 1'b1;
    @(posedge clk); #1;
    send_one("after reset", 32'h11035003, 1'b0, 32'h827B537B);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass,
             n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
